regfile_write_arbiter: RTL

Arbiter and sequencer for the single write port of the 32×32-bit register file. It shares that port between two independent requesters using round-robin arbitration with a one-cycle req/ack handshake. It also provides a clear sequence that writes zero to every register. It sits between the requesting datapath blocks and the register file's Write_Reg / write-address / W_Data inputs; the register file's read ports are not touched.

---
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter and clear sequencer for the register file's single write port.
// All outputs are registered; dbg_state exposes the FSM state (1 = CLEAR).
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              dbg_state
);

    // Handshake: a requester holds req/addr/data stable until it sees its ack
    // pulse, and must drop req before the next rising edge; a req still high at
    // that edge is a new request.

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_last;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_busy;

    state_t              w_state_nx;
    logic [ADDR_W-1:0]   w_cnt_nx;
    logic                w_last_nx;
    logic                w_write_nx;
    logic [ADDR_W-1:0]   w_addr_nx;
    logic [DATA_W-1:0]   w_data_nx;
    logic                w_ack0_nx;
    logic                w_ack1_nx;
    logic                w_busy_nx;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_last  <= w_last_nx;
            r_write <= w_write_nx;
            r_addr  <= w_addr_nx;
            r_data  <= w_data_nx;
            r_ack0  <= w_ack0_nx;
            r_ack1  <= w_ack1_nx;
            r_busy  <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        w_write_nx = 1'b0;
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        w_ack0_nx  = 1'b0;
        w_ack1_nx  = 1'b0;
        w_busy_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_start) begin
                    // The first clear write (address r_cnt == 0) issues on the entry edge.
                    w_state_nx = CLEAR;
                    w_write_nx = 1'b1;
                    w_addr_nx  = r_cnt;
                    w_data_nx  = '0;
                    w_busy_nx  = 1'b1;
                    w_cnt_nx   = r_cnt + 1'b1;
                end else if (req0 && (!req1 || r_last)) begin
                    w_write_nx = 1'b1;
                    w_addr_nx  = addr0;
                    w_data_nx  = data0;
                    w_ack0_nx  = 1'b1;
                    w_last_nx  = 1'b0;
                end else if (req1) begin
                    w_write_nx = 1'b1;
                    w_addr_nx  = addr1;
                    w_data_nx  = data1;
                    w_ack1_nx  = 1'b1;
                    w_last_nx  = 1'b1;
                end
            end
            CLEAR: begin
                w_write_nx = 1'b1;
                w_addr_nx  = r_cnt;
                w_data_nx  = '0;
                w_busy_nx  = 1'b1;
                w_cnt_nx   = r_cnt + 1'b1;
                // Counter wraps to 0 after the last address, ready for the next clear.
                if (r_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign Write_Reg = r_write;
    assign W_Addr    = r_addr;
    assign W_Data    = r_data;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign clr_busy  = r_busy;
    assign dbg_state = (r_state == CLEAR);

endmodule
